// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor, LSB first, start/done handshake

module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);
   assign d  = x ^ y;
   assign bo = ~x & y;
endmodule

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero
);
   // one extra counter bit so the terminal count never aliases to zero
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sa, sb, sr;
   logic [WIDTH-1:0] sr_nx;
   logic [CW-1:0]    count;
   logic             bff;
   logic             d1, b1, d_bit, b2, bo_bit;
   logic             last;

   // full subtractor for the current bit: two half subtractors plus OR
   half_subtractor u_hs0 (.x(sa[0]), .y(sb[0]), .d(d1),    .bo(b1));
   half_subtractor u_hs1 (.x(d1),    .y(bff),   .d(d_bit), .bo(b2));
   assign bo_bit = b1 | b2;

   assign sr_nx = {d_bit, sr[WIDTH-1:1]};
   assign last  = (count == CW'(WIDTH - 1));
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic: start only honoured in IDLE, DONE lasts one cycle
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = SHIFT;
         SHIFT:   if (last)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // datapath: operand capture, per-bit shift, result publish on the MSB edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa         <= '0;
         sb         <= '0;
         sr         <= '0;
         bff        <= 1'b0;
         count      <= '0;
         diff       <= '0;
         borrow_out <= 1'b0;
         zero       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  bff   <= 1'b0;
                  count <= '0;
               end
            end
            SHIFT: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               sr    <= sr_nx;
               bff   <= bo_bit;
               count <= count + CW'(1);
               if (last) begin
                  diff       <= sr_nx;
                  borrow_out <= bo_bit;
                  zero       <= (sr_nx == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end
endmodule
